// File: rtl/linear_move_sequencer.sv
// ---------------------------------------------------------------------------
// linear_move_sequencer
//
// Purpose:
//   Executes one G00/G01 linear opcode. It sets the servo pen position and
//   waits for the servo to settle if the pen position changes. It then
//   splits the signed per-axis step counts into segments of at most SEG_MAX
//   steps. Each segment is handed to the stepper units with a trigger/done
//   handshake. All state advances only on clock edges where i_clk_en is high.
//
// Optional build macro:
//   LINEAR_SEQ_ABS_EN - adds i_abs_mode and a signed (ARG_BITS+1)-bit position
//                       register per axis. With i_abs_mode=1 the args are
//                       absolute targets. Otherwise the args are relative
//                       moves that are added to the position.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_clk_en       enable tick
//   i_trigger_in   start request (sampled in IDLE only)
//   i_op           opcode; OP_G01 = pen down, anything else = pen up
//   i_arg1/i_arg2  signed x / y step counts (two's complement)
//   i_abs_mode     absolute-target select (LINEAR_SEQ_ABS_EN only)
//   i_done_in      stepper units finished the current segment
//   o_servo_pos    pen position
//   o_num_steps_x  x steps of the current segment
//   o_num_steps_y  y steps of the current segment
//   o_dir_x/o_dir_y 1 = negative direction
//   o_trigger_out  one-tick segment start pulse
//   o_done_out     one-tick operation complete pulse
//   o_busy         high in every state except IDLE
// ---------------------------------------------------------------------------
package Opcode_p;
  localparam int unsigned OP_G00 = 0;
  localparam int unsigned OP_G01 = 1;
endpackage

package Servo_p;
  typedef enum logic {
    SERVO_POS_UP   = 1'b0,
    SERVO_POS_DOWN = 1'b1
  } ServoPosition_t;
endpackage

module linear_move_sequencer #(
  parameter int OP_BITS        = 4,
  parameter int ARG_BITS       = 16,
  parameter int STEPPER_X_BITS = 8,
  parameter int STEPPER_Y_BITS = 8,
  parameter int SEG_MAX        = 255,
  parameter int SETTLE_TICKS   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clk_en,
  input  logic                      i_trigger_in,
  input  logic [OP_BITS-1:0]        i_op,
  input  logic [ARG_BITS-1:0]       i_arg1,
  input  logic [ARG_BITS-1:0]       i_arg2,
`ifdef LINEAR_SEQ_ABS_EN
  input  logic                      i_abs_mode,
`endif
  input  logic                      i_done_in,
  output Servo_p::ServoPosition_t   o_servo_pos,
  output logic [STEPPER_X_BITS-1:0] o_num_steps_x,
  output logic [STEPPER_Y_BITS-1:0] o_num_steps_y,
  output logic                      o_dir_x,
  output logic                      o_dir_y,
  output logic                      o_trigger_out,
  output logic                      o_done_out,
  output logic                      o_busy
);

  // An absolute move is the difference of two (ARG_BITS+1)-bit values.
  // That difference needs two extra bits beyond the argument width.
`ifdef LINEAR_SEQ_ABS_EN
  localparam int REM_W = ARG_BITS + 2;
`else
  localparam int REM_W = ARG_BITS;
`endif
  localparam int SET_W = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOAD,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  Servo_p::ServoPosition_t   r_servo_pos;
  Servo_p::ServoPosition_t   w_pen;
  logic [REM_W-1:0]          r_rem [2];
  logic [REM_W-1:0]          w_mag [2];
  logic [REM_W-1:0]          w_seg [2];
  logic                      w_neg [2];
  logic [ARG_BITS-1:0]       w_arg [2];
  logic [SET_W-1:0]          r_settle;
  logic [STEPPER_X_BITS-1:0] r_num_x;
  logic [STEPPER_Y_BITS-1:0] r_num_y;
  logic                      r_dir_x;
  logic                      r_dir_y;
  logic                      r_trigger;
  logic                      r_done;
  logic                      w_rem_zero;

  assign w_arg[0] = i_arg1;
  assign w_arg[1] = i_arg2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      logic [REM_W-1:0] w_delta;
`ifdef LINEAR_SEQ_ABS_EN
      logic [ARG_BITS:0] r_pos;
      logic [ARG_BITS:0] r_tgt;
      logic [ARG_BITS:0] w_arg_ext;
      logic [ARG_BITS:0] w_tgt;

      assign w_arg_ext = {w_arg[gi][ARG_BITS-1], w_arg[gi]};
      assign w_tgt     = i_abs_mode ? w_arg_ext : (r_pos + w_arg_ext);
      assign w_delta   = i_abs_mode ? ({w_tgt[ARG_BITS], w_tgt} - {r_pos[ARG_BITS], r_pos})
                                    : {w_arg_ext[ARG_BITS], w_arg_ext};

      // The target is captured at latch time and committed only at DONE.
      // An aborted move therefore leaves the position untouched.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_pos <= '0;
          r_tgt <= '0;
        end else if (i_clk_en) begin
          if (r_state == ST_IDLE && i_trigger_in) r_tgt <= w_tgt;
          if (r_state == ST_DONE) r_pos <= r_tgt;
        end
      end
`else
      assign w_delta = w_arg[gi];
`endif
      // The magnitude is unsigned, so -2^(W-1) maps to 2^(W-1) without overflow.
      assign w_neg[gi] = w_delta[REM_W-1];
      assign w_mag[gi] = w_neg[gi] ? (REM_W'(0) - w_delta) : w_delta;
      assign w_seg[gi] = ($unsigned(32'(r_rem[gi])) > $unsigned(32'(SEG_MAX)))
                         ? REM_W'(SEG_MAX) : r_rem[gi];
    end
  endgenerate

  assign w_rem_zero = (r_rem[0] == '0) && (r_rem[1] == '0);
  assign w_pen      = (i_op == OP_BITS'(Opcode_p::OP_G01)) ? Servo_p::SERVO_POS_DOWN
                                                           : Servo_p::SERVO_POS_UP;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_trigger_in) w_state_next = (w_pen != r_servo_pos) ? ST_SETTLE : ST_LOAD;
      ST_SETTLE: if (r_settle == '0) w_state_next = ST_LOAD;
      ST_LOAD:   w_state_next = w_rem_zero ? ST_DONE : ST_WAIT;
      ST_WAIT:   if (i_done_in) w_state_next = ST_LOAD;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_servo_pos <= Servo_p::SERVO_POS_UP;
      r_rem[0]    <= '0;
      r_rem[1]    <= '0;
      r_settle    <= '0;
      r_num_x     <= '0;
      r_num_y     <= '0;
      r_dir_x     <= 1'b0;
      r_dir_y     <= 1'b0;
      r_trigger   <= 1'b0;
      r_done      <= 1'b0;
    end else if (i_clk_en) begin
      r_state   <= w_state_next;
      // The pulses are cleared on every tick, so each lasts exactly one tick.
      r_trigger <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_trigger_in) begin
            r_rem[0] <= w_mag[0];
            r_rem[1] <= w_mag[1];
            r_dir_x  <= w_neg[0];
            r_dir_y  <= w_neg[1];
            if (w_pen != r_servo_pos) begin
              r_servo_pos <= w_pen;
              r_settle    <= SET_W'(SETTLE_TICKS);
            end
          end
        end
        ST_SETTLE: begin
          if (r_settle != '0) r_settle <= r_settle - SET_W'(1);
        end
        ST_LOAD: begin
          if (!w_rem_zero) begin
            r_num_x   <= STEPPER_X_BITS'(w_seg[0]);
            r_num_y   <= STEPPER_Y_BITS'(w_seg[1]);
            r_rem[0]  <= r_rem[0] - w_seg[0];
            r_rem[1]  <= r_rem[1] - w_seg[1];
            r_trigger <= 1'b1;
          end
        end
        ST_DONE: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_servo_pos   = r_servo_pos;
  assign o_num_steps_x = r_num_x;
  assign o_num_steps_y = r_num_y;
  assign o_dir_x       = r_dir_x;
  assign o_dir_y       = r_dir_y;
  assign o_trigger_out = r_trigger;
  assign o_done_out    = r_done;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_linear_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_linear_move_sequencer
//
// Directed bench for linear_move_sequencer with the default parameters
// (ARG_BITS=16, 8-bit step counts, SEG_MAX=255, SETTLE_TICKS=16).
// run_op computes the segment list and the tick-by-tick expected outputs
// of each operation from the move rules. A negedge process compares every
// DUT output against those expectations on every cycle. Literal values
// pin segment counts, step counts and latencies.
// If LINEAR_SEQ_ABS_EN is defined, the bench also drives i_abs_mode and
// runs the absolute-move sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_linear_move_sequencer;
  localparam int SEG    = 255;
  localparam int SETTLE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_en = 1'b0;
  logic        trigger_in = 1'b0;
  logic        done_in = 1'b0;
  logic [3:0]  op = '0;
  logic [15:0] arg1 = '0;
  logic [15:0] arg2 = '0;
`ifdef LINEAR_SEQ_ABS_EN
  logic        abs_mode = 1'b0;
`endif
  Servo_p::ServoPosition_t servo_pos;
  logic [7:0]  nsx, nsy;
  logic        dir_x, dir_y, trig_out, done_out, busy;

  linear_move_sequencer #(
    .OP_BITS(4), .ARG_BITS(16), .STEPPER_X_BITS(8), .STEPPER_Y_BITS(8),
    .SEG_MAX(SEG), .SETTLE_TICKS(SETTLE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_trigger_in(trigger_in),
    .i_op(op), .i_arg1(arg1), .i_arg2(arg2),
`ifdef LINEAR_SEQ_ABS_EN
    .i_abs_mode(abs_mode),
`endif
    .i_done_in(done_in), .o_servo_pos(servo_pos),
    .o_num_steps_x(nsx), .o_num_steps_y(nsy), .o_dir_x(dir_x), .o_dir_y(dir_y),
    .o_trigger_out(trig_out), .o_done_out(done_out), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected outputs, maintained by run_op
  logic       chk_on = 1'b0;
  logic       e_busy = 0, e_trig = 0, e_done = 0, e_servo = 0, e_dx = 0, e_dy = 0;
  logic [7:0] e_nx = 0, e_ny = 0;

  // observations for the literal pins
  int tick_no = 0, trig_cnt = 0, done_cnt = 0;
  int first_trig_tick = -1, done_tick = -1, latch_tick = 0, last_donein_tick = 0;
  logic [7:0] last_nx = 0, last_ny = 0;
  logic       last_dx = 0, last_dy = 0;

  // model state
  int pos_x = 0, pos_y = 0;
  int mdl_nseg = 0, mdl_seg0_x = 0, mdl_seg0_y = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("trigger_out", 32'(trig_out), 32'(e_trig));
      check("done_out", 32'(done_out), 32'(e_done));
      check("servo_pos", 32'(servo_pos), 32'(e_servo));
      check("num_steps_x", 32'(nsx), 32'(e_nx));
      check("num_steps_y", 32'(nsy), 32'(e_ny));
      check("dir_x", 32'(dir_x), 32'(e_dx));
      check("dir_y", 32'(dir_y), 32'(e_dy));
    end
  end

  // One enabled clock edge. Pulse expectations default low afterwards.
  task automatic tick();
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    tick_no++;
    e_trig = 1'b0;
    e_done = 1'b0;
    if (trig_out === 1'b1) begin
      trig_cnt++;
      if (first_trig_tick < 0) first_trig_tick = tick_no;
      last_nx = nsx; last_ny = nsy; last_dx = dir_x; last_dy = dir_y;
    end
    if (done_out === 1'b1) begin
      done_cnt++;
      done_tick = tick_no;
    end
  endtask

  task automatic run_op(input int opv, input int a1, input int a2, input bit absm,
                        input int wait_k, input bit noise, input bit stall, input int abort_seg);
    int dx, dy, rx, ry;
    int sx[$];
    int sy[$];
    logic pen;
    pen = (opv == 1);
    if (absm) begin dx = a1 - pos_x; dy = a2 - pos_y; end
    else begin dx = a1; dy = a2; end
    rx = (dx < 0) ? -dx : dx;
    ry = (dy < 0) ? -dy : dy;
    while (rx > 0 || ry > 0) begin
      sx.push_back((rx > SEG) ? SEG : rx);
      sy.push_back((ry > SEG) ? SEG : ry);
      rx -= sx[$];
      ry -= sy[$];
    end
    mdl_nseg = sx.size();
    mdl_seg0_x = (mdl_nseg > 0) ? sx[0] : 0;
    mdl_seg0_y = (mdl_nseg > 0) ? sy[0] : 0;
    $display("op=%0d arg1=%0d arg2=%0d abs=%0d segments=%0d", opv, a1, a2, absm, mdl_nseg);
    first_trig_tick = -1;
    done_tick = -1;

    op = 4'(opv); arg1 = a1[15:0]; arg2 = a2[15:0];
`ifdef LINEAR_SEQ_ABS_EN
    abs_mode = absm;
`endif
    trigger_in = 1'b1;
    tick();
    latch_tick = tick_no;
    trigger_in = 1'b0;
    e_busy = 1'b1;
    e_dx = (dx < 0);
    e_dy = (dy < 0);

    if (pen != e_servo) begin
      e_servo = pen;
      if (noise) begin
        // requests and done pulses while settling must have no effect
        trigger_in = 1'b1; done_in = 1'b1; op = ~op; arg1 = 16'h1234; arg2 = 16'h0042;
      end
      repeat (SETTLE + 1) tick();
      trigger_in = 1'b0;
      done_in = 1'b0;
    end

    for (int s = 0; s < sx.size(); s++) begin
      tick();
      e_trig = 1'b1;
      e_nx = 8'(sx[s]);
      e_ny = 8'(sy[s]);
      repeat (wait_k) tick();
      if (s == abort_seg) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_servo", 32'(servo_pos), 0);
        check("rst_nx", 32'(nsx), 0);
        check("rst_dy", 32'(dir_y), 0);
        e_busy = 0; e_trig = 0; e_done = 0; e_servo = 0;
        e_nx = 0; e_ny = 0; e_dx = 0; e_dy = 0;
        pos_x = 0; pos_y = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        return;
      end
      if (stall && s == 0) begin
        done_in = 1'b1;
        clk_en = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
      end
      done_in = 1'b1;
      tick();
      last_donein_tick = tick_no;
      done_in = 1'b0;
    end
    tick();
    tick();
    e_done = 1'b1;
    e_busy = 1'b0;
    pos_x += dx;
    pos_y += dy;
    tick();
  endtask

  initial begin
    int t0, d0;
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // G00 600/100 with the servo already up; clk_en stalled in the first WAIT
    t0 = trig_cnt; d0 = done_cnt;
    run_op(0, 600, 100, 0, 2, 0, 1, -1);
    check("t2_mdl_nseg", 32'(mdl_nseg), 3);
    check("t2_mdl_seg0_x", 32'(mdl_seg0_x), 255);
    check("t2_mdl_seg0_y", 32'(mdl_seg0_y), 100);
    check("t2_trigs", 32'(trig_cnt - t0), 3);
    check("t2_dones", 32'(done_cnt - d0), 1);
    check("t2_last_nx", 32'(last_nx), 90);
    check("t2_last_ny", 32'(last_ny), 0);
    check("t2_trig_latency", 32'(first_trig_tick - latch_tick), 1);
    check("t2_done_latency", 32'(done_tick - last_donein_tick), 2);

    // G01 10/-3 from pen up: settle, then one segment
    t0 = trig_cnt;
    run_op(1, 10, -3, 0, 2, 1, 0, -1);
    check("t1_trigs", 32'(trig_cnt - t0), 1);
    check("t1_nx", 32'(last_nx), 10);
    check("t1_ny", 32'(last_ny), 3);
    check("t1_dx", 32'(last_dx), 0);
    check("t1_dy", 32'(last_dy), 1);
    check("t1_trig_latency", 32'(first_trig_tick - latch_tick), 18);

    // reset during WAIT of the second segment
    d0 = done_cnt;
    run_op(1, 300, -5, 0, 1, 0, 0, 1);
    tick();
    check("rst_no_done", 32'(done_cnt - d0), 0);

    // zero move after reset: settle only, no trigger
    t0 = trig_cnt; d0 = done_cnt;
    run_op(1, 0, 0, 0, 0, 0, 0, -1);
    check("zero_trigs", 32'(trig_cnt - t0), 0);
    check("zero_dones", 32'(done_cnt - d0), 1);
    check("zero_done_latency", 32'(done_tick - latch_tick), 19);

    // exact SEG_MAX on x, one step over on y
    t0 = trig_cnt;
    run_op(1, 255, -256, 0, 0, 0, 0, -1);
    check("seg_edge_trigs", 32'(trig_cnt - t0), 2);
    check("seg_edge_last_nx", 32'(last_nx), 0);
    check("seg_edge_last_ny", 32'(last_ny), 1);

    // most negative argument: magnitude 32768 = 128*255 + 128
    t0 = trig_cnt;
    run_op(0, -32768, 1, 0, 0, 0, 0, -1);
    check("minneg_trigs", 32'(trig_cnt - t0), 129);
    check("minneg_last_nx", 32'(last_nx), 128);
    check("minneg_dx", 32'(last_dx), 1);

`ifdef LINEAR_SEQ_ABS_EN
    run_op(0, 50, 50, 1, 0, 0, 0, -1);
    t0 = trig_cnt;
    run_op(0, 20, 80, 1, 1, 0, 0, -1);
    check("abs_trigs", 32'(trig_cnt - t0), 1);
    check("abs_nx", 32'(last_nx), 30);
    check("abs_dx", 32'(last_dx), 1);
    check("abs_ny", 32'(last_ny), 30);
    check("abs_dy", 32'(last_dy), 0);
`endif

    repeat (3) tick();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
